vram_writer: RTL and testbench
==============================

// Module: vram_writer
// PURPOSE
//  CPU-side writer for the mini-VGA text video RAM: the JML-8 bus writes cursor, data
//  and control registers; the block turns them into single-cycle tile writes
//  (row, col, char) into the video RAM that the scan-out path reads.
//  Also provides a hardware clear-screen fill and cursor auto-advance with wrap.
// PARAMETERS
//  HTILES   80  tiles per row (640/8); column range 0..HTILES-1
//  VTILES   60  tile rows (480/8); row range 0..VTILES-1
//  COL_W    7   column bits, clog2(HTILES)
//  ROW_W    6   row bits, clog2(VTILES)
// PORTS
//  clk          in   1      system clock, single domain
//  rst_n        in   1      asynchronous active-low reset
//  cpu_cs_n     in   1      chip select, async to clk, active low
//  cpu_wr_n     in   1      write strobe, async to clk, active low
//  cpu_addr     in   2      register select: 0=CURX 1=CURY 2=DATA 3=CTRL
//  cpu_din      in   8      write data from CPU
//  cpu_dout     out  8      readback: CURX/CURY/last DATA/{7'b0,busy}
//  busy         out  1      high while clear fill runs
//  vram_we      out  1      one-cycle write enable to video RAM
//  vram_row     out  ROW_W  tile row of the write
//  vram_col     out  COL_W  tile column of the write
//  vram_data    out  8      character code written
// BEHAVIOUR
//  Reset: all outputs 0; CURX=0, CURY=0, DATA=0, autoinc=1, FSM=IDLE.
//  Bus sync: cs_n, wr_n through 2-flop synchronizers. While sync cs&wr both low,
//   addr/din are captured every cycle. Commit on sync wr_n rising edge with cs low on
//   the previous cycle. Exactly one commit per CPU write cycle.
//  Latency: commit detected in cycle n -> register update / vram_we high in cycle n+1.
//   vram_we never high for more than one cycle per DATA write.
//  CURX write: accepted if din < HTILES, else ignored. CURY: accepted if din < VTILES.
//  DATA write: vram_we=1, row=CURY, col=CURX, data=din; DATA reg=din. If autoinc:
//   col+1; col HTILES-1 -> col 0, row+1; row VTILES-1 & col HTILES-1 -> (0,0).
//  CTRL write: bit1 -> autoinc := din[1]. bit0=1 -> start clear with fill char = DATA
//   reg; cursor reset to (0,0).
//  FSM: IDLE --clear--> FILL. FILL writes one tile per cycle, vram_we=1, row-major
//   from (0,0) to (VTILES-1,HTILES-1): HTILES*VTILES=4800 cycles -> IDLE.
//   busy=1 exactly for the FILL cycles.
//  During FILL: CURX/CURY/DATA writes dropped; CTRL clear restarts fill at (0,0);
//   CTRL autoinc bit still applied. Readback of addr 3 returns busy.
//  cpu_dout: combinational mux on cpu_addr, zero-extended; driven regardless of cs.
//  Reset mid-FILL: FSM to IDLE, busy=0, vram_we=0 immediately (async).
//  Counters sized COL_W/ROW_W; no width overflow, wrap is explicit compare.
// STRUCTURE
//  vgaspecs.vh: HTILES, VTILES, COL_W, ROW_W, register address constants,
//   FSM state encodings (IDLE, FILL).
//  Sub-module bus_sync: 2-flop synchronizer + rising-edge detect for wr_n
//   (reusable by other JML-8 peripherals). Rest is cursor/register/FSM logic.
// TESTING
//  CURX=5, CURY=2, DATA=0x41 -> one vram_we pulse, row=2 col=5 data=0x41; CURX reads 6.
//  CURX=79, CURY=59, DATA=0x42 -> write at (59,79), cursor wraps to (0,0).
//  CTRL=0x00 (autoinc off), DATA 0x43 twice -> two writes both at same (row,col).
//  DATA=0x20 then CTRL=0x03 -> busy 4800 cycles, 4800 writes of 0x20 covering all
//   tiles once; DATA write mid-fill produces no extra write.
//  CURX=80 / CURY=60 writes -> ignored, registers keep prior values.
//  Assert rst_n low at fill cycle 100 -> busy, vram_we drop to 0 at once; after
//   release CURX=CURY=0, no writes until next CPU access.

Source files
------------

// File: rtl/vram_writer_pkg.sv
// Shared constants and types for the text-mode video RAM writer.
// Tile geometry, register map and FSM state encoding.
package vram_writer_pkg;

  localparam int unsigned HTILES = 80;
  localparam int unsigned VTILES = 60;
  localparam int unsigned COL_W  = 7;
  localparam int unsigned ROW_W  = 6;

  localparam logic [7:0]       HtilesByte = 8'(HTILES);
  localparam logic [7:0]       VtilesByte = 8'(VTILES);
  localparam logic [COL_W-1:0] ColLast    = COL_W'(HTILES - 1);
  localparam logic [ROW_W-1:0] RowLast    = ROW_W'(VTILES - 1);

  localparam logic [1:0] AddrCurx = 2'd0;
  localparam logic [1:0] AddrCury = 2'd1;
  localparam logic [1:0] AddrData = 2'd2;
  localparam logic [1:0] AddrCtrl = 2'd3;

  typedef enum logic {
    StIdle,
    StFill
  } state_e;

endpackage

// File: rtl/vram_writer_if.sv
// CPU register bus plus video RAM write port of the text VRAM writer.
// The writer sits on the slave side; the CPU/VRAM environment uses master.
interface vram_writer_if;
  import vram_writer_pkg::*;

  logic             cpu_cs_n;
  logic             cpu_wr_n;
  logic [1:0]       cpu_addr;
  logic [7:0]       cpu_din;
  logic [7:0]       cpu_dout;
  logic             busy;
  logic             vram_we;
  logic [ROW_W-1:0] vram_row;
  logic [COL_W-1:0] vram_col;
  logic [7:0]       vram_data;

  modport slave (
    input  cpu_cs_n, cpu_wr_n, cpu_addr, cpu_din,
    output cpu_dout, busy, vram_we, vram_row, vram_col, vram_data
  );

  modport master (
    output cpu_cs_n, cpu_wr_n, cpu_addr, cpu_din,
    input  cpu_dout, busy, vram_we, vram_row, vram_col, vram_data
  );

endinterface

// File: rtl/vram_writer_bus_sync.sv
// Two-flop synchronizers for JML-8 chip select / write strobe, with a
// capture window and a single-cycle commit pulse on the wr_n rising edge.
module vram_writer_bus_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic cs_n,
  input  logic wr_n,
  output logic active,
  output logic commit
);

  logic [1:0] cs_sync_q, wr_sync_q;
  logic       cs_prev_q, wr_prev_q;

  // Idle-high reset so a released bus never looks like a write edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs_sync_q <= 2'b11;
      wr_sync_q <= 2'b11;
      cs_prev_q <= 1'b1;
      wr_prev_q <= 1'b1;
    end else begin
      cs_sync_q <= {cs_sync_q[0], cs_n};
      wr_sync_q <= {wr_sync_q[0], wr_n};
      cs_prev_q <= cs_sync_q[1];
      wr_prev_q <= wr_sync_q[1];
    end
  end

  assign active = ~cs_sync_q[1] & ~wr_sync_q[1];
  assign commit = wr_sync_q[1] & ~wr_prev_q & ~cs_prev_q;

endmodule

// File: rtl/vram_writer.sv
// CPU-side writer for the text video RAM: cursor/data/control registers,
// single-cycle tile writes with cursor auto-advance, and a clear-screen fill.
module vram_writer
  import vram_writer_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  vram_writer_if.slave   bus
);

  logic active, commit;

  vram_writer_bus_sync u_bus_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .cs_n   (bus.cpu_cs_n),
    .wr_n   (bus.cpu_wr_n),
    .active (active),
    .commit (commit)
  );

  state_e           state_q, state_d;
  logic [1:0]       addr_q, addr_d;
  logic [7:0]       din_q, din_d;
  logic [COL_W-1:0] curx_q, curx_d, fill_col_q, fill_col_d, wr_col_q, wr_col_d;
  logic [ROW_W-1:0] cury_q, cury_d, fill_row_q, fill_row_d, wr_row_q, wr_row_d;
  logic [7:0]       data_q, data_d, fill_char_q, fill_char_d, wr_data_q, wr_data_d;
  logic             autoinc_q, autoinc_d, we_q, we_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      din_q       <= '0;
      curx_q      <= '0;
      cury_q      <= '0;
      data_q      <= '0;
      autoinc_q   <= 1'b1;
      fill_col_q  <= '0;
      fill_row_q  <= '0;
      fill_char_q <= '0;
      we_q        <= 1'b0;
      wr_col_q    <= '0;
      wr_row_q    <= '0;
      wr_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      din_q       <= din_d;
      curx_q      <= curx_d;
      cury_q      <= cury_d;
      data_q      <= data_d;
      autoinc_q   <= autoinc_d;
      fill_col_q  <= fill_col_d;
      fill_row_q  <= fill_row_d;
      fill_char_q <= fill_char_d;
      we_q        <= we_d;
      wr_col_q    <= wr_col_d;
      wr_row_q    <= wr_row_d;
      wr_data_q   <= wr_data_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = active ? bus.cpu_addr : addr_q;
    din_d       = active ? bus.cpu_din : din_q;
    curx_d      = curx_q;
    cury_d      = cury_q;
    data_d      = data_q;
    autoinc_d   = autoinc_q;
    fill_col_d  = fill_col_q;
    fill_row_d  = fill_row_q;
    fill_char_d = fill_char_q;
    we_d        = 1'b0;
    wr_col_d    = wr_col_q;
    wr_row_d    = wr_row_q;
    wr_data_d   = wr_data_q;

    unique case (state_q)
      StIdle: begin
        if (commit) begin
          unique case (addr_q)
            AddrCurx: if (din_q < HtilesByte) curx_d = din_q[COL_W-1:0];
            AddrCury: if (din_q < VtilesByte) cury_d = din_q[ROW_W-1:0];
            AddrData: begin
              we_d      = 1'b1;
              wr_row_d  = cury_q;
              wr_col_d  = curx_q;
              wr_data_d = din_q;
              data_d    = din_q;
              if (autoinc_q) begin
                if (curx_q == ColLast) begin
                  curx_d = '0;
                  cury_d = (cury_q == RowLast) ? '0 : cury_q + 1'b1;
                end else begin
                  curx_d = curx_q + 1'b1;
                end
              end
            end
            AddrCtrl: ;
          endcase
        end
      end
      StFill: begin
        if (fill_col_q == ColLast) begin
          fill_col_d = '0;
          if (fill_row_q == RowLast) begin
            fill_row_d = '0;
            state_d    = StIdle;
          end else begin
            fill_row_d = fill_row_q + 1'b1;
          end
        end else begin
          fill_col_d = fill_col_q + 1'b1;
        end
      end
    endcase

    // Control writes are honoured in both states; a clear mid-fill restarts at (0,0).
    if (commit && addr_q == AddrCtrl) begin
      autoinc_d = din_q[1];
      if (din_q[0]) begin
        state_d     = StFill;
        fill_col_d  = '0;
        fill_row_d  = '0;
        fill_char_d = data_q;
        curx_d      = '0;
        cury_d      = '0;
      end
    end
  end

  assign bus.busy      = (state_q == StFill);
  assign bus.vram_we   = we_q | bus.busy;
  assign bus.vram_row  = bus.busy ? fill_row_q : wr_row_q;
  assign bus.vram_col  = bus.busy ? fill_col_q : wr_col_q;
  assign bus.vram_data = bus.busy ? fill_char_q : wr_data_q;

  always_comb begin
    bus.cpu_dout = '0;
    unique case (bus.cpu_addr)
      AddrCurx: bus.cpu_dout = 8'(curx_q);
      AddrCury: bus.cpu_dout = 8'(cury_q);
      AddrData: bus.cpu_dout = data_q;
      AddrCtrl: bus.cpu_dout = {7'b0, bus.busy};
    endcase
  end

endmodule

// File: tb/tb_vram_writer.sv
// Bench for vram_writer: directed scenarios plus random register traffic, all
// checked against a tile-level model of expected video RAM writes.
module tb_vram_writer;
  import vram_writer_pkg::*;

  typedef struct {
    int row;
    int col;
    int data;
    bit fill;
  } wr_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  vram_writer_if bus_if ();

  vram_writer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  int  total = 0;
  int  bad = 0;
  wr_t exp_q[$];
  int  m_curx, m_cury, m_data, fill_left;
  bit  m_autoinc;
  int  n_writes = 0, fill_cnt = 0, busy_run = 0, last_busy_run = 0;
  int  last_row = -1, last_col = -1, last_data = -1;
  int  fill_hits[4800];

  function automatic int pack(int r, int c, int d);
    return r * 65536 + c * 256 + d;
  endfunction

  task automatic check(string name, int act, int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    m_curx = 0;
    m_cury = 0;
    m_data = 0;
    m_autoinc = 1'b1;
    fill_left = 0;
    exp_q.delete();
  endtask

  task automatic model_write(input int a, input int d);
    int lin;
    if (a == 3) begin
      m_autoinc = d[1];
      if (d[0]) begin
        m_curx = 0;
        m_cury = 0;
        for (int i = 0; i < 4800; i++) exp_q.push_back('{i / 80, i % 80, m_data, 1'b1});
        fill_left += 4800;
      end
    end else if (fill_left == 0) begin
      if (a == 0 && d < 80) m_curx = d;
      if (a == 1 && d < 60) m_cury = d;
      if (a == 2) begin
        exp_q.push_back('{m_cury, m_curx, d, 1'b0});
        m_data = d;
        if (m_autoinc) begin
          lin = (m_cury * 80 + m_curx + 1) % 4800;
          m_curx = lin % 80;
          m_cury = lin / 80;
        end
      end
    end
  endtask

  // Per-cycle compare of the VRAM write port against the expected write stream.
  always @(negedge clk) begin
    wr_t e;
    if (!rst_n) begin
      busy_run = 0;
    end else begin
      if (bus_if.busy) busy_run++;
      else if (busy_run != 0) begin
        last_busy_run = busy_run;
        busy_run = 0;
      end
      if (bus_if.vram_we) begin
        n_writes++;
        last_row = int'(bus_if.vram_row);
        last_col = int'(bus_if.vram_col);
        last_data = int'(bus_if.vram_data);
        check("write_expected", int'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("vram_write", pack(last_row, last_col, last_data), pack(e.row, e.col, e.data));
          check("busy_during_write", int'(bus_if.busy), int'(e.fill));
          if (e.fill) begin
            fill_left--;
            fill_cnt++;
            if (last_row < 60 && last_col < 80) fill_hits[last_row * 80 + last_col]++;
          end
        end
      end else begin
        check("busy_idle", int'(bus_if.busy), 0);
      end
    end
  end

  task automatic cpu_write(input int a, input int d);
    @(posedge clk);
    #3;
    bus_if.cpu_addr = 2'(a);
    bus_if.cpu_din = 8'(d);
    bus_if.cpu_cs_n = 1'b0;
    bus_if.cpu_wr_n = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    bus_if.cpu_wr_n = 1'b1;
    model_write(a, d);
    repeat (2) @(posedge clk);
    #3;
    bus_if.cpu_cs_n = 1'b1;
    repeat (4) @(posedge clk);
  endtask

  task automatic check_reg(input int a, input int req, input string name);
    bus_if.cpu_addr = 2'(a);
    #1;
    check(name, int'(bus_if.cpu_dout), req);
  endtask

  task automatic check_regs();
    check_reg(0, m_curx, "rd_curx");
    check_reg(1, m_cury, "rd_cury");
    check_reg(2, m_data, "rd_data");
    check_reg(3, int'(fill_left > 0), "rd_ctrl");
  endtask

  task automatic wait_idle(input int limit);
    int n = 0;
    while ((exp_q.size() != 0 || bus_if.busy) && n < limit) begin
      @(posedge clk);
      n++;
    end
    check("idle_timeout", int'(n >= limit), 0);
    repeat (3) @(posedge clk);
  endtask

  task automatic wait_fill(input int target, input int limit);
    int n = 0;
    while (fill_cnt < target && n < limit) begin
      @(negedge clk);
      n++;
    end
    check("fill_progress_timeout", int'(n >= limit), 0);
  endtask

  initial begin
    int n0, miss;
    bus_if.cpu_cs_n = 1'b1;
    bus_if.cpu_wr_n = 1'b1;
    bus_if.cpu_addr = 2'd0;
    bus_if.cpu_din = 8'd0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_we", int'(bus_if.vram_we), 0);
    check("rst_busy", int'(bus_if.busy), 0);
    check("rst_vram_out", pack(int'(bus_if.vram_row), int'(bus_if.vram_col),
                               int'(bus_if.vram_data)), 0);
    check_regs();
    @(negedge clk);
    rst_n = 1'b1;

    // Single write at (2,5) with auto-advance.
    n0 = n_writes;
    cpu_write(0, 5);
    cpu_write(1, 2);
    cpu_write(2, 8'h41);
    wait_idle(100);
    check("t1_count", n_writes - n0, 1);
    check("t1_write", pack(last_row, last_col, last_data), pack(2, 5, 8'h41));
    check_reg(0, 6, "t1_curx");
    check_reg(1, 2, "t1_cury");

    // Last tile wraps cursor to origin.
    cpu_write(0, 79);
    cpu_write(1, 59);
    cpu_write(2, 8'h42);
    wait_idle(100);
    check("t2_write", pack(last_row, last_col, last_data), pack(59, 79, 8'h42));
    check_reg(0, 0, "t2_curx");
    check_reg(1, 0, "t2_cury");

    // Auto-advance off: repeated writes hit the same tile.
    n0 = n_writes;
    cpu_write(3, 0);
    cpu_write(2, 8'h43);
    check("t3_first", pack(last_row, last_col, last_data), pack(0, 0, 8'h43));
    cpu_write(2, 8'h43);
    wait_idle(100);
    check("t3_count", n_writes - n0, 2);
    check("t3_second", pack(last_row, last_col, last_data), pack(0, 0, 8'h43));
    check_reg(0, 0, "t3_curx");

    // Out-of-range cursor values are ignored.
    cpu_write(0, 7);
    cpu_write(1, 3);
    cpu_write(0, 80);
    cpu_write(1, 60);
    check_reg(0, 7, "t5_curx");
    check_reg(1, 3, "t5_cury");

    // Clear-screen fill with a dropped DATA write in the middle.
    cpu_write(2, 8'h20);
    fill_cnt = 0;
    for (int i = 0; i < 4800; i++) fill_hits[i] = 0;
    last_busy_run = 0;
    cpu_write(3, 3);
    wait_fill(1000, 2000);
    check_reg(3, 1, "t4_busy_rd");
    cpu_write(2, 8'h55);
    wait_idle(6000);
    check("t4_busy_cycles", last_busy_run, 4800);
    check("t4_fill_writes", fill_cnt, 4800);
    miss = 0;
    for (int i = 0; i < 4800; i++) if (fill_hits[i] != 1) miss++;
    check("t4_tiles_once", miss, 0);
    check("t4_fill_char", last_data, 8'h20);
    check_reg(2, 8'h20, "t4_data");
    check_reg(0, 0, "t4_curx");
    check_reg(1, 0, "t4_cury");
    check_reg(3, 0, "t4_idle_rd");

    // Reset in the middle of a fill.
    fill_cnt = 0;
    cpu_write(3, 1);
    wait_fill(100, 500);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_busy", int'(bus_if.busy), 0);
    check("t6_we", int'(bus_if.vram_we), 0);
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    n0 = n_writes;
    repeat (20) @(posedge clk);
    check("t6_no_writes", n_writes - n0, 0);
    check_regs();

    // Random register traffic.
    for (int i = 0; i < 150; i++) begin
      int a, d;
      a = int'($urandom_range(0, 3));
      unique case (a)
        0: d = ($urandom_range(0, 3) == 0) ? int'($urandom_range(75, 85))
                                           : int'($urandom_range(0, 90));
        1: d = ($urandom_range(0, 3) == 0) ? int'($urandom_range(56, 64))
                                           : int'($urandom_range(0, 70));
        2: d = int'($urandom_range(0, 255));
        default: d = int'($urandom_range(0, 255)) & 8'hFE;
      endcase
      cpu_write(a, d);
      check_regs();
    end
    wait_idle(200);
    check("final_queue_empty", int'(exp_q.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
